// File: rtl/text_console_ctrl.sv
// Text console controller: turns a character stream into byte-lane writes on a
// 32-bit text RAM. Optional TEXTCON_CLEAR_ON_RESET_EN runs a full screen clear after reset.
module text_console_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [8:0]  write_address,
    output logic [31:0] write_data,
    output logic [3:0]  write_byteena,
    output logic        write_en
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int         WORDS     = COLS * ROWS / 4;
    localparam logic [8:0] LAST_WORD = 9'(WORDS - 1);
    localparam logic [6:0] COL_MAX   = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX   = 5'(ROWS - 1);

`ifdef TEXTCON_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t      state;
    state_t      state_next;
    logic [8:0]  clear_cnt;
    logic        accept;
    logic [10:0] row_base;
    logic [10:0] char_addr;
    logic [10:0] bs_addr;
    logic [6:0]  col_dec;

    assign busy       = (state == CLEAR);
    assign char_ready = (state == IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;

    assign row_base  = 11'(cursor_row) * 11'(COLS);
    assign char_addr = row_base + 11'(cursor_col);
    assign col_dec   = cursor_col - 7'd1;
    assign bs_addr   = row_base + 11'(col_dec);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A form feed only reaches here when no clear_req is pending, since it needs char_ready
                if (clear_req || (accept && char_data == 8'h0C)) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clear_cnt == LAST_WORD) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cursor_col    <= '0;
            cursor_row    <= '0;
            write_en      <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            write_byteena <= '0;
            clear_cnt     <= '0;
        end else begin
            write_en <= 1'b0;
            if (state == CLEAR) begin
                write_en      <= 1'b1;
                write_address <= clear_cnt;
                write_byteena <= 4'b1111;
                write_data    <= 32'h2020_2020;
                if (clear_cnt == LAST_WORD) begin
                    clear_cnt  <= '0;
                    cursor_col <= '0;
                    cursor_row <= '0;
                end else begin
                    clear_cnt <= clear_cnt + 9'd1;
                end
            end else if (accept) begin
                case (char_data)
                    8'h0D: cursor_col <= '0;
                    8'h0A: begin
                        cursor_col <= '0;
                        cursor_row <= (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
                    end
                    8'h08: begin
                        if (cursor_col != 7'd0) begin
                            cursor_col    <= col_dec;
                            write_en      <= 1'b1;
                            write_address <= bs_addr[10:2];
                            write_byteena <= 4'b0001 << bs_addr[1:0];
                            write_data    <= 32'h2020_2020;
                        end
                    end
                    8'h0C: begin
                    end
                    default: begin
                        write_en      <= 1'b1;
                        write_address <= char_addr[10:2];
                        write_byteena <= 4'b0001 << char_addr[1:0];
                        write_data    <= {4{char_data}};
                        // Wrap to the top of the screen instead of scrolling
                        if (cursor_col == COL_MAX) begin
                            cursor_col <= '0;
                            cursor_row <= (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
                        end else begin
                            cursor_col <= cursor_col + 7'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80: characters per row.
REQ-002 SHALL have parameter ROWS, default 25: rows per screen.
REQ-003 SHALL have port clk, input, 1: single clock, the text-RAM write-side clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port char_valid, input, 1: character byte offered.
REQ-006 SHALL have port char_data, input, 8: character byte (ASCII or control code).
REQ-007 SHALL have port char_ready, output, 1: character can be accepted this cycle.
REQ-008 SHALL have port clear_req, input, 1: request to clear the screen.
REQ-009 SHALL have port busy, output, 1: a clear is in progress.
REQ-010 SHALL have port cursor_col, output, 7: cursor column, 0..COLS-1.
REQ-011 SHALL have port cursor_row, output, 5: cursor row, 0..ROWS-1.
REQ-012 SHALL have port write_address, output, 9: text-RAM word address.
REQ-013 SHALL have port write_data, output, 32: text-RAM write data.
REQ-014 SHALL have port write_byteena, output, 4: text-RAM byte enables.
REQ-015 SHALL have port write_en, output, 1: text-RAM write strobe.

Function
REQ-016 SHALL implement FSM states IDLE and CLEAR; busy = (state == CLEAR).
REQ-017 SHALL drive char_ready = (state == IDLE) && !clear_req; a character is accepted when char_valid && char_ready; one character per cycle sustained.
REQ-018 SHALL compute byte address a = cursor_row*COLS + cursor_col (11 bits, max 1999).
REQ-019 SHALL write a printable character (any code other than 0x08/0x0A/0x0C/0x0D) as follows, registered, in the cycle after acceptance: write_en=1, write_address=a[10:2], write_byteena=4'b0001<<a[1:0], write_data={4{char_data}}.
REQ-020 SHALL, after a printable write, advance the cursor: col+1; if col was COLS-1 then col=0 and row+1; if row was ROWS-1 then row=0 (wrap to top, no scroll).
REQ-021 SHALL handle 0x0D (CR) by setting col=0, with no write.
REQ-022 SHALL handle 0x0A (LF) by setting col=0 and row+1 (wrapping ROWS-1 to 0), with no write.
REQ-023 SHALL handle 0x08 (BS) when col>0 by setting col-1 and writing 0x20 at the new position (per REQ-019); at col=0, no write and no cursor change.
REQ-024 SHALL handle 0x0C (FF) by entering CLEAR exactly as for clear_req.
REQ-025 SHALL, when clear_req=1 in IDLE, enter CLEAR on the next edge; clear_req takes priority over a simultaneous char_valid (the character is not accepted).
REQ-026 SHALL, in CLEAR, write words 0..(COLS*ROWS/4-1) on consecutive cycles (500 at default) with write_en=1, write_byteena=4'b1111, write_data=32'h20202020.
REQ-027 SHALL, after the last CLEAR word, set cursor to (0,0) and return to IDLE in the same edge.
REQ-028 SHALL ignore clear_req while in CLEAR.
REQ-029 SHALL drive write_en=0 in every cycle with no write; write_address, write_data and write_byteena then hold their last values.

Reset
REQ-030 SHALL, on resetn low, immediately set cursor_col=0, cursor_row=0, write_en=0, write_address=0, write_data=0, write_byteena=0, and clear word counter=0.
REQ-031 SHALL, on resetn low, set state=IDLE (busy=0), unless TEXTCON_CLEAR_ON_RESET_EN applies.
REQ-032 SHALL, when reset is asserted mid-CLEAR, abort the clear with no further writes.

Configuration
REQ-033 SHALL, when TEXTCON_CLEAR_ON_RESET_EN is defined, make the reset state CLEAR with counter 0, so the full clear sequence runs automatically after reset release.
REQ-034 SHALL, when TEXTCON_CLEAR_ON_RESET_EN is undefined, make the reset state IDLE with no automatic clear.

Verification
REQ-035 SHALL verify printable write: reset, send 0x41 -> next cycle write_en=1, addr=0, byteena=0001, data=0x41414141; cursor (row 0, col 1).
REQ-036 SHALL verify byte lane and row advance: cursor (row 0, col 79), send 0x42 -> addr=19, byteena=1000; cursor (row 1, col 0).
REQ-037 SHALL verify screen wrap: cursor (row 24, col 79), send 0x43 -> addr=499, byteena=1000; cursor (row 0, col 0).
REQ-038 SHALL verify control codes: cursor (row 3, col 10), send 0x0D then 0x0A -> no write_en, cursor (row 4, col 0); then 0x08 -> no write, cursor unchanged.
REQ-039 SHALL verify clear: clear_req pulse with simultaneous char_valid -> char not accepted; busy=1 for 500 cycles; 500 writes at addr 0..499, data 0x20202020, byteena 1111; cursor (0,0).
REQ-040 SHALL verify reset mid-clear: assert resetn=0 at word 100 -> write_en=0 at once; after release, busy=0 (macro undefined) or a fresh 500-word clear starting at addr 0 (macro defined).
